pipe_csa_addsub: RTL
====================

PIPE_CSA_ADDSUB -- requirements
Module: pipe_csa_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of SEG, 8..64.
REQ-002 SHALL have parameter SEG, default 8, carry-select segment width; N = WIDTH/SEG segments, with N >= 2.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts beat this cycle.
REQ-007 SHALL have ports A and B, input, WIDTH each, operands.
REQ-008 SHALL have port cin, input, 1, carry-in, used for add only.
REQ-009 SHALL have port sub, input, 1: 0 = A+B+cin, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1, result beat present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port S, output, WIDTH, result.
REQ-013 SHALL have ports Cout, Ovf and Zero, output, 1 each: carry-out, signed overflow, result-equals-zero.

Function
REQ-014 Transfer SHALL occur on in_valid&in_ready (input) and on out_valid&out_ready (output); a beat SHALL never be dropped or duplicated.
REQ-015 Sub SHALL use B' = ~B with carry-in forced to 1; add SHALL use B' = B and carry-in = cin.
REQ-016 Stage 1 SHALL register segment 0's sum and carry using the true carry-in.
REQ-017 Stage 1 SHALL also register, for each segment 1..N-1, two precomputed sums and carries: one for carry-in 0 and one for carry-in 1.
REQ-018 Stage 1 SHALL register sign(A), the sub bit and s1_valid.
REQ-019 Stage 2 SHALL select each segment's result via a mux chain driven by the previous segment's selected carry.
REQ-020 Stage 2 SHALL register S, Cout, Ovf, Zero and s2_valid.
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be 1 beat per cycle.
REQ-022 Stage 2 SHALL load when !s2_valid | out_ready; stage 1 SHALL load when !s1_valid | stage-2 load.
REQ-023 in_ready SHALL equal !s1_valid | stage-2 load (combinational); the block SHALL hold at most 2 beats.
REQ-024 Stalled stage registers SHALL hold their contents unchanged; out_valid SHALL NOT drop while out_ready is low.
REQ-025 Cout SHALL be the raw MSB carry; for sub, Cout=1 means no borrow.
REQ-026 Ovf SHALL equal carry-into-MSB XOR Cout, computed on the unsaturated sum.
REQ-027 Zero SHALL be 1 iff the final S (after any saturation) equals 0.
REQ-028 Results SHALL be issued in acceptance order.

Reset
REQ-029 While reset is high at a clock edge: s1_valid, s2_valid and out_valid SHALL become 0, and S, Cout, Ovf and Zero SHALL become 0.
REQ-030 During the reset cycle in_ready SHALL be 0; in-flight beats SHALL be discarded.
REQ-031 The first accept SHALL occur no earlier than the cycle after reset deasserts.

Configuration
REQ-032 When macro CSA_SAT_EN is defined and Ovf=1, S SHALL saturate to 2^(WIDTH-1)-1 if A was non-negative, else to -2^(WIDTH-1).
REQ-033 With CSA_SAT_EN defined, Cout and Ovf SHALL be unchanged by saturation.
REQ-034 When CSA_SAT_EN is undefined, S SHALL wrap modulo 2^WIDTH; the interface SHALL be identical in both builds.

Verification (WIDTH=32, SEG=8)
REQ-035 Reset held 2 cycles -> out_valid=0, S=0, Cout/Ovf/Zero=0, in_ready=0 during reset.
REQ-036 Add A=0x0000FFFF, B=1, cin=0, out_ready=1 -> 2 cycles later S=0x00010000, Cout=0, Ovf=0, Zero=0 (carry crosses segments 0-1).
REQ-037 Sub A=5, B=7 -> S=0xFFFFFFFE, Cout=0, Ovf=0; then sub A=7, B=7 -> S=0, Cout=1, Zero=1.
REQ-038 Add A=0x7FFFFFFF, B=1 -> without CSA_SAT_EN S=0x80000000, Ovf=1; with CSA_SAT_EN S=0x7FFFFFFF, Ovf=1.
REQ-039 Backpressure: 4 back-to-back beats, out_ready=0 for cycles 0-4 -> exactly 2 beats accepted, then in_ready=0; outputs stay stable; after out_ready rises all 4 results emerge in order with none lost.
REQ-040 Reset asserted with 2 beats in flight -> out_valid=0 next cycle; neither in-flight result ever appears on the output.

Source files
------------

// File: rtl/pipe_csa_addsub.sv
// Two-stage carry-select adder/subtractor with valid/ready handshake on both sides.
// Optional build macro CSA_SAT_EN saturates S on signed overflow; by default S wraps.
module pipe_csa_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int N = WIDTH / SEG;

  // Stage 1: effective operand and carry-in, segment sums for both possible carries
  logic [WIDTH-1:0]        b_eff;
  logic                    c_in_eff;
  logic [SEG:0]            seg0_d;
  logic [N-1:1][SEG:0]     alt0_d;
  logic [N-1:1][SEG:0]     alt1_d;

  assign b_eff    = sub ? ~B : B;
  assign c_in_eff = sub | cin;
  assign seg0_d   = {1'b0, A[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, c_in_eff};

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_seg
      assign alt0_d[gi] = {1'b0, A[gi*SEG +: SEG]} + {1'b0, b_eff[gi*SEG +: SEG]};
      assign alt1_d[gi] = {1'b0, A[gi*SEG +: SEG]} + {1'b0, b_eff[gi*SEG +: SEG]}
                          + {{SEG{1'b0}}, 1'b1};
    end
  endgenerate

  logic                s1_valid_q;
  logic [SEG:0]        seg0_q;
  logic [N-1:1][SEG:0] alt0_q;
  logic [N-1:1][SEG:0] alt1_q;
  logic                a_sign_q;
  logic                b_sign_q;
  logic                sub_q;

  logic                s2_valid_q;
  logic [WIDTH-1:0]    s_q;
  logic                cout_q;
  logic                ovf_q;
  logic                zero_q;

  // Stage 2: carry ripples only through the per-segment select muxes
  logic [WIDTH-1:0] s_raw;
  logic             carry;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] s_d;
  logic             zero_d;
  logic             c_into_msb;

  always_comb begin
    carry           = seg0_q[SEG];
    s_raw           = '0;
    s_raw[SEG-1:0]  = seg0_q[SEG-1:0];
    for (int i = 1; i < N; i++) begin
      s_raw[i*SEG +: SEG] = carry ? alt1_q[i][SEG-1:0] : alt0_q[i][SEG-1:0];
      carry               = carry ? alt1_q[i][SEG]     : alt0_q[i][SEG];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and the MSB operand bits
  assign cout_d     = carry;
  assign c_into_msb = s_raw[WIDTH-1] ^ a_sign_q ^ (b_sign_q ^ sub_q);
  assign ovf_d      = c_into_msb ^ cout_d;

`ifdef CSA_SAT_EN
  assign s_d = !ovf_d   ? s_raw :
               a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign s_d = s_raw;
`endif
  assign zero_d = (s_d == '0);

  // Handshake: a stage advances when the stage after it is empty or advancing
  logic ld2;
  logic ld1;
  assign ld2      = !s2_valid_q | out_ready;
  assign ld1      = !s1_valid_q | ld2;
  assign in_ready = !reset & ld1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      seg0_q     <= '0;
      alt0_q     <= '0;
      alt1_q     <= '0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
      sub_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (ld1) begin
        s1_valid_q <= in_valid;
      end
      if (ld1 && in_valid) begin
        seg0_q   <= seg0_d;
        alt0_q   <= alt0_d;
        alt1_q   <= alt1_d;
        a_sign_q <= A[WIDTH-1];
        b_sign_q <= B[WIDTH-1];
        sub_q    <= sub;
      end
      if (ld2) begin
        s2_valid_q <= s1_valid_q;
      end
      if (ld2 && s1_valid_q) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;
endmodule
